// File: rtl/swt16_arb_pkg.sv
// Shared types for the IF/MEM memory arbiter: FSM state encoding, owner ids
// and the wait-state counter width helper.
package swt16_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  // At least one bit so WAIT_STATES=0 still yields a legal counter.
  function automatic int cnt_width(input int wait_states);
    int w;
    w = $clog2(wait_states + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/swt16_mem_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and the memory macro.
// slave = arbiter side, master = requester/memory side.
interface swt16_mem_arbiter_if #(
  parameter int AW = 12,
  parameter int WW = 16
);
  logic          in_if_req;
  logic [AW-1:0] in_if_addr;
  logic          out_if_gnt;
  logic          out_if_valid;
  logic [WW-1:0] out_if_rdata;
  logic          out_stall_if;
  logic          in_mem_req;
  logic          in_mem_we;
  logic [AW-1:0] in_mem_addr;
  logic [WW-1:0] in_mem_wdata;
  logic          out_mem_gnt;
  logic          out_mem_valid;
  logic [WW-1:0] out_mem_rdata;
  logic          out_ram_en;
  logic          out_ram_we;
  logic [AW-1:0] out_ram_addr;
  logic [WW-1:0] out_ram_wdata;
  logic [WW-1:0] in_ram_rdata;

  modport slave (
    input  in_if_req, in_if_addr, in_mem_req, in_mem_we, in_mem_addr, in_mem_wdata,
           in_ram_rdata,
    output out_if_gnt, out_if_valid, out_if_rdata, out_stall_if,
           out_mem_gnt, out_mem_valid, out_mem_rdata,
           out_ram_en, out_ram_we, out_ram_addr, out_ram_wdata
  );

  modport master (
    output in_if_req, in_if_addr, in_mem_req, in_mem_we, in_mem_addr, in_mem_wdata,
           in_ram_rdata,
    input  out_if_gnt, out_if_valid, out_if_rdata, out_stall_if,
           out_mem_gnt, out_mem_valid, out_mem_rdata,
           out_ram_en, out_ram_we, out_ram_addr, out_ram_wdata
  );
endinterface

// File: rtl/swt16_arb_prio.sv
// Grant picker for the IF/MEM arbiter. Build option SWT16_ARB_RR_EN selects
// round robin on ties; otherwise MEM has fixed priority over IF.
module swt16_arb_prio
  import swt16_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   mem_req,
  input  owner_t last_owner,
  output logic   gnt_if,
  output logic   gnt_mem
);

`ifdef SWT16_ARB_RR_EN
  always_comb begin
    gnt_if  = 1'b0;
    gnt_mem = 1'b0;
    if (if_req && mem_req) begin
      if (last_owner == OWN_MEM) gnt_if  = 1'b1;
      else                       gnt_mem = 1'b1;
    end else begin
      gnt_if  = if_req;
      gnt_mem = mem_req;
    end
  end
`else
  // The MEM stage holds the older instruction, so it always goes first.
  assign gnt_mem = mem_req;
  assign gnt_if  = if_req && !mem_req;
`endif

endmodule

// File: rtl/swt16_mem_arbiter.sv
// Single-port memory arbiter between fetch (IF, read-only) and memory stage
// (MEM, read/write). Tie policy selected by SWT16_ARB_RR_EN in swt16_arb_prio.
//
// state     | meaning
// ST_IDLE   | grants issued combinationally; request latched on grant
// ST_ACCESS | ram_en high, counting down wait states; read data captured at 0
// ST_RESP   | one-cycle valid pulse to the owner
module swt16_mem_arbiter
  import swt16_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WORD_WIDTH  = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                clock,
  input  logic                reset,
  swt16_mem_arbiter_if.slave  bus
);

  localparam int             CW       = cnt_width(WAIT_STATES);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WAIT_STATES);

  state_t                 state_q, state_d;
  owner_t                 owner_q, last_owner_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   we_q;
  logic [WORD_WIDTH-1:0]  wdata_q;
  logic [WORD_WIDTH-1:0]  if_rdata_q, mem_rdata_q;
  logic [CW-1:0]          cnt_q;
  logic                   pick_if, pick_mem;
  logic                   gnt_if, gnt_mem;

  swt16_arb_prio u_prio (
    .if_req     (bus.in_if_req),
    .mem_req    (bus.in_mem_req),
    .last_owner (last_owner_q),
    .gnt_if     (pick_if),
    .gnt_mem    (pick_mem)
  );

  // Gated by reset so nothing is granted while reset is held.
  assign gnt_if  = reset && (state_q == ST_IDLE) && pick_if;
  assign gnt_mem = reset && (state_q == ST_IDLE) && pick_mem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (gnt_if || gnt_mem) state_d = ST_ACCESS;
      ST_ACCESS: if (cnt_q == '0)       state_d = ST_RESP;
      ST_RESP:                          state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_mem) begin
            addr_q       <= bus.in_mem_addr;
            we_q         <= bus.in_mem_we;
            wdata_q      <= bus.in_mem_wdata;
            owner_q      <= OWN_MEM;
            last_owner_q <= OWN_MEM;
            cnt_q        <= CNT_LOAD;
          end else if (gnt_if) begin
            addr_q       <= bus.in_if_addr;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            cnt_q        <= CNT_LOAD;
          end
        end
        ST_ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (owner_q == OWN_MEM) begin
            mem_rdata_q <= we_q ? '0 : bus.in_ram_rdata;
          end else begin
            if_rdata_q <= bus.in_ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.out_if_gnt    = gnt_if;
    bus.out_mem_gnt   = gnt_mem;
    bus.out_stall_if  = reset && bus.in_if_req && !gnt_if;
    bus.out_if_valid  = 1'b0;
    bus.out_mem_valid = 1'b0;
    bus.out_ram_en    = 1'b0;
    bus.out_ram_we    = 1'b0;
    bus.out_ram_addr  = '0;
    bus.out_ram_wdata = '0;
    case (state_q)
      ST_ACCESS: begin
        bus.out_ram_en    = 1'b1;
        bus.out_ram_we    = we_q;
        bus.out_ram_addr  = addr_q;
        bus.out_ram_wdata = wdata_q;
      end
      ST_RESP: begin
        bus.out_if_valid  = (owner_q == OWN_IF);
        bus.out_mem_valid = (owner_q == OWN_MEM);
      end
      default: ;
    endcase
  end

  assign bus.out_if_rdata  = if_rdata_q;
  assign bus.out_mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_swt16_mem_arbiter.sv
// Self-checking bench for swt16_mem_arbiter: WAIT_STATES=1 main instance plus
// WAIT_STATES=0 and 3 instances for latency; expectations from a timing/memory model.
module tb_swt16_mem_arbiter;
  localparam int AW = 12;
  localparam int WW = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  swt16_mem_arbiter_if #(.AW(AW), .WW(WW)) b1 ();
  swt16_mem_arbiter_if #(.AW(AW), .WW(WW)) b0 ();
  swt16_mem_arbiter_if #(.AW(AW), .WW(WW)) b3 ();

  swt16_mem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WAIT_STATES(1)) dut1 (.clock(clock), .reset(reset), .bus(b1));
  swt16_mem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WAIT_STATES(0)) dut0 (.clock(clock), .reset(reset), .bus(b0));
  swt16_mem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WAIT_STATES(3)) dut3 (.clock(clock), .reset(reset), .bus(b3));

  function automatic logic [WW-1:0] pattern(input logic [AW-1:0] a);
    return (a == 12'h010) ? 16'hBEEF : ({4'hC, a} ^ 16'h0F0F);
  endfunction

  // Memory macro model for the main instance; fixed-pattern ROMs for the others.
  logic [WW-1:0] ram1 [0:(1<<AW)-1];
  assign b1.in_ram_rdata = ram1[b1.out_ram_addr];
  assign b0.in_ram_rdata = pattern(b0.out_ram_addr);
  assign b3.in_ram_rdata = pattern(b3.out_ram_addr);
  always @(posedge clock)
    if (b1.out_ram_en && b1.out_ram_we) ram1[b1.out_ram_addr] <= b1.out_ram_wdata;

  // Reference model: memory contents by completed writes, and arbitration history.
  logic [WW-1:0] ref_mem [int];
  bit            ref_last_mem = 1'b0;
  localparam int LAT = 3;   // WAIT_STATES + 2 for the main instance

  function automatic logic [WW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pattern(a);
  endfunction

  function automatic bit tie_goes_to_mem();
`ifdef SWT16_ARB_RR_EN
    return !ref_last_mem;
`else
    return 1'b1;
`endif
  endfunction

  task automatic test_reset();
    logic [6:0] obs;
    b1.in_if_req = 1'b1; b1.in_if_addr = 12'h004;
    b1.in_mem_req = 1'b1; b1.in_mem_we = 1'b0; b1.in_mem_addr = 12'h040; b1.in_mem_wdata = '0;
    repeat (2) @(negedge clock);
    #1;
    obs = {b1.out_if_gnt, b1.out_mem_gnt, b1.out_if_valid, b1.out_mem_valid,
           b1.out_stall_if, b1.out_ram_en, b1.out_ram_we};
    n_cmp++;
    if (obs !== 7'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 0000000", obs); end
    n_cmp++;
    if ({b1.out_if_rdata, b1.out_mem_rdata, b1.out_ram_addr, b1.out_ram_wdata} !== '0) begin
      n_err++; $display("FAIL reset_data: if_rdata %h mem_rdata %h ram_addr %h want 0",
                        b1.out_if_rdata, b1.out_mem_rdata, b1.out_ram_addr);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({b1.out_mem_gnt, b1.out_if_gnt, b1.out_stall_if} !== 3'b101) begin
      n_err++; $display("FAIL reset_first_tie: mem_gnt/if_gnt/stall %b want 101",
                        {b1.out_mem_gnt, b1.out_if_gnt, b1.out_stall_if});
    end
    ref_last_mem = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 1) begin b1.in_if_req = 1'b0; b1.in_mem_req = 1'b0; end
      #1;
      if (k == LAT) begin
        n_cmp++;
        if (b1.out_mem_valid !== 1'b1 || b1.out_mem_rdata !== ref_read(12'h040)) begin
          n_err++; $display("FAIL reset_first_access: valid %b rdata %h want 1 %h",
                            b1.out_mem_valid, b1.out_mem_rdata, ref_read(12'h040));
        end
      end
    end
  endtask

  task automatic test_if_read();
    @(negedge clock);
    b1.in_if_req = 1'b1; b1.in_if_addr = 12'h010;
    #1;
    n_cmp++;
    if (b1.out_if_gnt !== 1'b1 || b1.out_stall_if !== 1'b0) begin
      n_err++; $display("FAIL if_read_gnt: gnt %b stall %b want 1 0", b1.out_if_gnt, b1.out_stall_if);
    end
    ref_last_mem = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 1) b1.in_if_req = 1'b0;
      #1;
      n_cmp++;
      if (b1.out_ram_en !== (k <= 2) || (k <= 2 && (b1.out_ram_addr !== 12'h010 || b1.out_ram_we !== 1'b0))) begin
        n_err++; $display("FAIL if_read_ram k=%0d: en %b addr %h we %b want %b 010 0",
                          k, b1.out_ram_en, b1.out_ram_addr, b1.out_ram_we, k <= 2);
      end
      n_cmp++;
      if (b1.out_if_valid !== (k == LAT) || b1.out_stall_if !== 1'b0) begin
        n_err++; $display("FAIL if_read_valid k=%0d: valid %b stall %b want %b 0",
                          k, b1.out_if_valid, b1.out_stall_if, k == LAT);
      end
    end
    n_cmp++;
    if (b1.out_if_rdata !== 16'hBEEF) begin
      n_err++; $display("FAIL if_read_data: got %h want BEEF", b1.out_if_rdata);
    end
  endtask

  task automatic test_contention();
    bit            mem_first;
    logic [AW-1:0] a_if, a_mem;
    for (int r = 0; r < 4; r++) begin
      a_if  = 12'($urandom_range(0, 63));
      a_mem = 12'($urandom_range(64, 127));
      @(negedge clock);
      b1.in_if_req = 1'b1; b1.in_if_addr = a_if;
      b1.in_mem_req = 1'b1; b1.in_mem_we = 1'b0; b1.in_mem_addr = a_mem;
      #1;
      mem_first = tie_goes_to_mem();
      n_cmp++;
      if (b1.out_mem_gnt !== mem_first || b1.out_if_gnt !== !mem_first || b1.out_stall_if !== mem_first) begin
        n_err++; $display("FAIL tie_round%0d: mem_gnt %b if_gnt %b stall %b want %b %b %b", r,
                          b1.out_mem_gnt, b1.out_if_gnt, b1.out_stall_if, mem_first, !mem_first, mem_first);
      end
      ref_last_mem = mem_first;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clock);
        if (k == 1) begin if (mem_first) b1.in_mem_req = 1'b0; else b1.in_if_req = 1'b0; end
        if (k == 5) begin b1.in_mem_req = 1'b0; b1.in_if_req = 1'b0; end
        #1;
        if (k < 4) begin
          n_cmp++;
          if (b1.out_if_gnt !== 1'b0 || b1.out_mem_gnt !== 1'b0 || b1.out_stall_if !== mem_first) begin
            n_err++; $display("FAIL tie_wait r%0d k=%0d: gnt %b%b stall %b want 00 %b", r, k,
                              b1.out_if_gnt, b1.out_mem_gnt, b1.out_stall_if, mem_first);
          end
        end
        if (k == 4) begin
          n_cmp++;
          if (b1.out_if_gnt !== mem_first || b1.out_mem_gnt !== !mem_first) begin
            n_err++; $display("FAIL tie_second_gnt r%0d: if_gnt %b mem_gnt %b want %b %b", r,
                              b1.out_if_gnt, b1.out_mem_gnt, mem_first, !mem_first);
          end
          ref_last_mem = !mem_first;
        end
        if (k == 4 + LAT) begin
          n_cmp++;
          if (mem_first ? (b1.out_if_valid !== 1'b1 || b1.out_if_rdata !== ref_read(a_if))
                        : (b1.out_mem_valid !== 1'b1 || b1.out_mem_rdata !== ref_read(a_mem))) begin
            n_err++; $display("FAIL tie_second_done r%0d: if %b/%h mem %b/%h", r,
                              b1.out_if_valid, b1.out_if_rdata, b1.out_mem_valid, b1.out_mem_rdata);
          end
        end
      end
    end
  endtask

  task automatic test_write_readback();
    for (int j = 0; j < 2; j++) begin
      @(negedge clock);
      b1.in_mem_req = 1'b1; b1.in_mem_we = (j == 0); b1.in_mem_addr = 12'h020; b1.in_mem_wdata = 16'h1234;
      #1;
      n_cmp++;
      if (b1.out_mem_gnt !== 1'b1) begin n_err++; $display("FAIL wr_rd_gnt j=%0d: got %b want 1", j, b1.out_mem_gnt); end
      ref_last_mem = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clock);
        if (k == 1) b1.in_mem_req = 1'b0;
        #1;
        if (k <= 2) begin
          n_cmp++;
          if (b1.out_ram_en !== 1'b1 || b1.out_ram_we !== (j == 0) || b1.out_ram_addr !== 12'h020 ||
              (j == 0 && b1.out_ram_wdata !== 16'h1234)) begin
            n_err++; $display("FAIL wr_rd_ram j=%0d k=%0d: en %b we %b addr %h wdata %h", j, k,
                              b1.out_ram_en, b1.out_ram_we, b1.out_ram_addr, b1.out_ram_wdata);
          end
        end
        if (k == LAT) begin
          n_cmp++;
          if (b1.out_mem_valid !== 1'b1 || b1.out_mem_rdata !== ((j == 0) ? 16'h0000 : 16'h1234)) begin
            n_err++; $display("FAIL wr_rd_done j=%0d: valid %b rdata %h want 1 %h", j,
                              b1.out_mem_valid, b1.out_mem_rdata, (j == 0) ? 16'h0000 : 16'h1234);
          end
        end
      end
      if (j == 0) ref_mem[int'(12'h020)] = 16'h1234;
    end
  endtask

  task automatic test_random();
    int            kind;
    bit            win_mem, ewe;
    logic [AW-1:0] ea, a_if, a_mem;
    logic [WW-1:0] ed, exp_rd;
    for (int n = 0; n < 24; n++) begin
      kind  = $urandom_range(0, 3);
      a_if  = 12'($urandom_range(0, 7));
      a_mem = 12'($urandom_range(0, 7));
      ed    = 16'($urandom);
      ewe   = (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1);
      @(negedge clock);
      b1.in_if_req  = (kind == 0) || (kind == 3); b1.in_if_addr = a_if;
      b1.in_mem_req = (kind != 0); b1.in_mem_we = ewe; b1.in_mem_addr = a_mem; b1.in_mem_wdata = ed;
      #1;
      win_mem = (kind == 3) ? tie_goes_to_mem() : (kind != 0);
      ea      = win_mem ? a_mem : a_if;
      if (!win_mem) ewe = 1'b0;
      n_cmp++;
      if (b1.out_mem_gnt !== win_mem || b1.out_if_gnt !== !win_mem) begin
        n_err++; $display("FAIL rand_gnt n=%0d kind=%0d: mem_gnt %b if_gnt %b want %b %b", n, kind,
                          b1.out_mem_gnt, b1.out_if_gnt, win_mem, !win_mem);
      end
      ref_last_mem = win_mem;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clock);
        if (k == 1) begin b1.in_if_req = 1'b0; b1.in_mem_req = 1'b0; end
        #1;
        n_cmp++;
        if (b1.out_ram_en !== (k <= 2) || (k <= 2 && (b1.out_ram_addr !== ea || b1.out_ram_we !== ewe ||
            (ewe && b1.out_ram_wdata !== ed)))) begin
          n_err++; $display("FAIL rand_ram n=%0d k=%0d: en %b addr %h we %b wdata %h want %b %h %b %h", n, k,
                            b1.out_ram_en, b1.out_ram_addr, b1.out_ram_we, b1.out_ram_wdata, k <= 2, ea, ewe, ed);
        end
        if (k == LAT) begin
          exp_rd = ewe ? 16'h0000 : ref_read(ea);
          n_cmp++;
          if (b1.out_mem_valid !== win_mem || b1.out_if_valid !== !win_mem ||
              (win_mem ? b1.out_mem_rdata : b1.out_if_rdata) !== exp_rd) begin
            n_err++; $display("FAIL rand_done n=%0d: mem_v %b if_v %b rdata %h want %b %b %h", n,
                              b1.out_mem_valid, b1.out_if_valid, win_mem ? b1.out_mem_rdata : b1.out_if_rdata,
                              win_mem, !win_mem, exp_rd);
          end
          if (ewe) ref_mem[int'(ea)] = ed;
        end
      end
    end
  endtask

  task automatic test_reset_during_access();
    @(negedge clock);
    b1.in_mem_req = 1'b1; b1.in_mem_we = 1'b0; b1.in_mem_addr = 12'h030;
    #1;
    n_cmp++;
    if (b1.out_mem_gnt !== 1'b1) begin n_err++; $display("FAIL rst_mid_gnt: got %b want 1", b1.out_mem_gnt); end
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (b1.out_ram_en !== 1'b0 || b1.out_mem_valid !== 1'b0 || b1.out_mem_rdata !== '0) begin
      n_err++; $display("FAIL rst_mid_drop: en %b valid %b rdata %h want 0 0 0",
                        b1.out_ram_en, b1.out_mem_valid, b1.out_mem_rdata);
    end
    b1.in_mem_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1;
      n_cmp++;
      if (b1.out_ram_en !== 1'b0 || b1.out_mem_valid !== 1'b0) begin
        n_err++; $display("FAIL rst_mid_hold k=%0d: en %b valid %b want 0 0", k, b1.out_ram_en, b1.out_mem_valid);
      end
    end
    reset = 1'b1;
    ref_last_mem = 1'b0;
    @(negedge clock);
    b1.in_mem_req = 1'b1;
    #1;
    n_cmp++;
    if (b1.out_mem_gnt !== 1'b1) begin n_err++; $display("FAIL rst_mid_regnt: got %b want 1", b1.out_mem_gnt); end
    ref_last_mem = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 1) b1.in_mem_req = 1'b0;
      #1;
      if (k == LAT) begin
        n_cmp++;
        if (b1.out_mem_valid !== 1'b1 || b1.out_mem_rdata !== ref_read(12'h030)) begin
          n_err++; $display("FAIL rst_mid_reissue: valid %b rdata %h want 1 %h",
                            b1.out_mem_valid, b1.out_mem_rdata, ref_read(12'h030));
        end
      end
    end
  endtask

  task automatic drive_ws(input int idx, input logic req, input logic [AW-1:0] a);
    if (idx == 0) begin b0.in_if_req = req; b0.in_if_addr = a; end
    else          begin b3.in_if_req = req; b3.in_if_addr = a; end
  endtask

  function automatic logic [WW+2:0] obs_ws(input int idx);
    if (idx == 0) return {b0.out_if_gnt, b0.out_ram_en, b0.out_if_valid, b0.out_if_rdata};
    return {b3.out_if_gnt, b3.out_ram_en, b3.out_if_valid, b3.out_if_rdata};
  endfunction

  task automatic test_wait_states();
    logic [WW+2:0] o;
    logic [AW-1:0] a;
    logic [WW-1:0] got;
    int            w, lat, en_cnt;
    for (int idx = 0; idx < 2; idx++) begin
      w = (idx == 0) ? 0 : 3;
      a = 12'($urandom_range(256, 511));
      @(negedge clock);
      drive_ws(idx, 1'b1, a);
      #1;
      o = obs_ws(idx);
      n_cmp++;
      if (o[WW+2] !== 1'b1) begin n_err++; $display("FAIL ws%0d_gnt: got %b want 1", w, o[WW+2]); end
      lat = 0; en_cnt = 0; got = '0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
        @(negedge clock);
        if (k == 1) drive_ws(idx, 1'b0, a);
        #1;
        o = obs_ws(idx);
        if (o[WW+1]) en_cnt++;
        if (o[WW]) begin lat = k; got = o[WW-1:0]; end
      end
      n_cmp++;
      if (lat != w + 2 || en_cnt != w + 1) begin
        n_err++; $display("FAIL ws%0d_latency: valid after %0d (0=timeout) en %0d cycles want %0d %0d",
                          w, lat, en_cnt, w + 2, w + 1);
      end
      n_cmp++;
      if (got !== pattern(a)) begin n_err++; $display("FAIL ws%0d_data: got %h want %h", w, got, pattern(a)); end
      repeat (2) @(negedge clock);
    end
  endtask

  task automatic test_if_drop_before_gnt();
    int en_cnt;
    bit if_granted;
    @(negedge clock);
    b1.in_mem_req = 1'b1; b1.in_mem_we = 1'b0; b1.in_mem_addr = 12'h050;
    #1;
    ref_last_mem = 1'b1;
    en_cnt = 0; if_granted = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) begin b1.in_mem_req = 1'b0; b1.in_if_req = 1'b1; b1.in_if_addr = 12'h060; end
      if (k == 3) b1.in_if_req = 1'b0;
      #1;
      if (b1.out_ram_en) en_cnt++;
      if (b1.out_if_gnt) if_granted = 1'b1;
      if (k <= 2) begin
        n_cmp++;
        if (b1.out_stall_if !== 1'b1) begin n_err++; $display("FAIL drop_stall k=%0d: got %b want 1", k, b1.out_stall_if); end
      end
    end
    n_cmp++;
    if (en_cnt != 2 || if_granted) begin
      n_err++; $display("FAIL drop_no_access: ram_en cycles %0d if_gnt seen %b want 2 0", en_cnt, if_granted);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram1[i] = pattern(12'(i));
    {b1.in_if_req, b1.in_mem_req, b1.in_mem_we} = '0;
    {b1.in_if_addr, b1.in_mem_addr, b1.in_mem_wdata} = '0;
    {b0.in_if_req, b0.in_mem_req, b0.in_mem_we, b0.in_if_addr, b0.in_mem_addr, b0.in_mem_wdata} = '0;
    {b3.in_if_req, b3.in_mem_req, b3.in_mem_we, b3.in_if_addr, b3.in_mem_addr, b3.in_mem_wdata} = '0;
    test_reset();
    test_if_read();
    test_contention();
    test_write_readback();
    test_random();
    test_reset_during_access();
    test_wait_states();
    test_if_drop_before_gnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
